// File: rtl/fifo_rr_scheduler.sv
// Drains N_FIFOS input FIFOs into one output FIFO, one word per cycle, with round-robin arbitration.
// Define STRICT_PRIO_EN to replace round-robin with fixed priority (lowest non-empty index wins).
module fifo_rr_scheduler #(
  parameter int N_FIFOS   = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 3,
  parameter int FULL_DEF  = 3,
  parameter int EMPTY_DEF = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init,
  input  logic [PTR_L-1:0]               full_threshold_in,
  input  logic [PTR_L-1:0]               empty_threshold_in,
  input  logic [N_FIFOS-1:0]             fifo_empty_in,
  input  logic [N_FIFOS-1:0]             fifo_error_in,
  input  logic [N_FIFOS*WORD_SIZE-1:0]   fifo_data_in,
  input  logic                           out_almost_full,
  input  logic                           out_fifo_full,
  input  logic                           out_error,
  output logic [N_FIFOS-1:0]             fifo_rd,
  output logic                           out_wr,
  output logic [WORD_SIZE-1:0]           out_data,
  output logic [PTR_L-1:0]               full_threshold,
  output logic [PTR_L-1:0]               empty_threshold,
  output logic [4:0]                     state,
  output logic                           idle,
  output logic                           error
);

  localparam int SEL_W = (N_FIFOS > 1) ? $clog2(N_FIFOS) : 1;

  localparam logic [4:0] S_RESET  = 5'b00001;
  localparam logic [4:0] S_INIT   = 5'b00010;
  localparam logic [4:0] S_IDLE   = 5'b00100;
  localparam logic [4:0] S_ACTIVE = 5'b01000;
  localparam logic [4:0] S_ERROR  = 5'b10000;

  // Handshake: fifo_rd is a one-cycle pop strobe; the popped FIFO presents its word the next
  // cycle, when out_wr pushes it unconditionally. There is no back-pressure on an in-flight word,
  // so out_almost_full must assert while the output FIFO still has one free entry.

  logic [SEL_W-1:0]     grant;
  logic                 grant_vld;
  logic [SEL_W-1:0]     rd_sel;
  logic [SEL_W-1:0]     wr_sel;
  logic                 in_flight;
  logic                 any_ready;
  logic                 err_det;
  logic                 pop_ok;
  logic [4:0]           state_nxt;
  logic [WORD_SIZE-1:0] data_hold;
  logic [WORD_SIZE-1:0] cur_word;
  logic [WORD_SIZE-1:0] words [N_FIFOS];

  for (genvar g = 0; g < N_FIFOS; g++) begin : g_unpack
    assign words[g] = fifo_data_in[g*WORD_SIZE +: WORD_SIZE];
  end

  assign cur_word  = words[wr_sel];
  assign out_data  = out_wr ? cur_word : data_hold;
  assign in_flight = |fifo_rd;
  assign any_ready = |(~fifo_empty_in);
  assign idle      = (state == S_IDLE);
  assign error     = (state == S_ERROR);

  assign err_det = (state != S_RESET) &&
                   ((|fifo_error_in) || out_error || (out_wr && out_fifo_full));

  // A pop is only issued when the FSM stays in ACTIVE, so leaving ACTIVE never starts a new word.
  assign pop_ok = (state == S_ACTIVE) && !err_det && !init && !out_almost_full && grant_vld;

`ifdef STRICT_PRIO_EN
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = N_FIFOS - 1; i >= 0; i--) begin
      if (!fifo_empty_in[i]) begin
        grant     = SEL_W'(i);
        grant_vld = 1'b1;
      end
    end
  end
`else
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] cand;

  // Scan from farthest to nearest so the candidate closest after rr_ptr is the last one kept.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = N_FIFOS; k >= 1; k--) begin
      cand = SEL_W'((int'(rr_ptr) + k) % N_FIFOS);
      if (!fifo_empty_in[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= SEL_W'(N_FIFOS - 1);
    end else if (pop_ok) begin
      rr_ptr <= grant;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    if (state == S_RESET) begin
      state_nxt = S_INIT;
    end else if (err_det || state == S_ERROR) begin
      state_nxt = S_ERROR;
    end else begin
      case (state)
        S_INIT:   state_nxt = init ? S_INIT : S_IDLE;
        S_IDLE:   state_nxt = init ? S_INIT : (any_ready ? S_ACTIVE : S_IDLE);
        S_ACTIVE: state_nxt = init ? S_INIT :
                              ((!any_ready && !in_flight) ? S_IDLE : S_ACTIVE);
        default:  state_nxt = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_RESET;
      fifo_rd         <= '0;
      out_wr          <= 1'b0;
      rd_sel          <= '0;
      wr_sel          <= '0;
      data_hold       <= '0;
      full_threshold  <= PTR_L'(FULL_DEF);
      empty_threshold <= PTR_L'(EMPTY_DEF);
    end else begin
      state   <= state_nxt;
      fifo_rd <= '0;
      out_wr  <= in_flight;
      wr_sel  <= rd_sel;
      if (out_wr) begin
        data_hold <= cur_word;
      end
      if (pop_ok) begin
        fifo_rd <= N_FIFOS'(1) << grant;
        rd_sel  <= grant;
      end
      if (state == S_INIT && init) begin
        full_threshold  <= full_threshold_in;
        empty_threshold <= empty_threshold_in;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: behavioural input FIFOs, grant/data scoreboard, directed scenarios.
module tb_fifo_rr_scheduler;

  localparam int N = 4;
  localparam int W = 6;
  localparam int P = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           init;
  logic [P-1:0]   full_threshold_in;
  logic [P-1:0]   empty_threshold_in;
  logic [N-1:0]   fifo_empty_in;
  logic [N-1:0]   fifo_error_in;
  logic [N*W-1:0] fifo_data_in;
  logic           out_almost_full;
  logic           out_fifo_full;
  logic           out_error;
  logic [N-1:0]   fifo_rd;
  logic           out_wr;
  logic [W-1:0]   out_data;
  logic [P-1:0]   full_threshold;
  logic [P-1:0]   empty_threshold;
  logic [4:0]     state;
  logic           idle;
  logic           error;

  fifo_rr_scheduler dut (
    .clk                (clk),
    .reset              (reset),
    .init               (init),
    .full_threshold_in  (full_threshold_in),
    .empty_threshold_in (empty_threshold_in),
    .fifo_empty_in      (fifo_empty_in),
    .fifo_error_in      (fifo_error_in),
    .fifo_data_in       (fifo_data_in),
    .out_almost_full    (out_almost_full),
    .out_fifo_full      (out_fifo_full),
    .out_error          (out_error),
    .fifo_rd            (fifo_rd),
    .out_wr             (out_wr),
    .out_data           (out_data),
    .full_threshold     (full_threshold),
    .empty_threshold    (empty_threshold),
    .state              (state),
    .idle               (idle),
    .error              (error)
  );

  always #5 clk = ~clk;

  // Input FIFO models: pop on fifo_rd at posedge, read data valid the following cycle.
  // The empty flag already accounts for a pop strobe in the current cycle.
  logic [W-1:0] mem    [N][8];
  logic [7:0]   wr_cnt [N] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0]   rd_cnt [N] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [W-1:0] data_q [N] = '{6'd0, 6'd0, 6'd0, 6'd0};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (fifo_rd[i]) begin
        data_q[i] <= mem[i][rd_cnt[i][2:0]];
        rd_cnt[i] <= rd_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    fifo_empty_in = '0;
    fifo_data_in  = '0;
    for (int i = 0; i < N; i++) begin
      fifo_empty_in[i] = ((wr_cnt[i] - rd_cnt[i]) == {7'd0, fifo_rd[i]});
      fifo_data_in[i*W +: W] = data_q[i];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  int           exp_g_q[$];
  logic         mon_en  = 1'b0;
  logic         prev_rd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] mk_word(input int f, input int s);
    return W'((f << 4) | (s & 15));
  endfunction

  task automatic push_word(input int f, input int s);
    mem[f][wr_cnt[f][2:0]] = mk_word(f, s);
    wr_cnt[f] = wr_cnt[f] + 8'd1;
  endtask

  task automatic expect_pop(input int f, input int s);
    exp_g_q.push_back(f);
    exp_q.push_back(mk_word(f, s));
  endtask

  task automatic monitor();
    int g;
    logic [W-1:0] d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("wr_after_rd", 32'(out_wr), 32'(prev_rd));
        if (fifo_rd != '0) begin
          if (exp_g_q.size() == 0) chk("grant_unexpected", 32'(fifo_rd), 32'd0);
          else begin
            g = exp_g_q.pop_front();
            chk("grant", 32'(fifo_rd), 32'(1) << g);
          end
        end
        if (out_wr) begin
          if (exp_q.size() == 0) chk("data_unexpected", 32'(out_data), 32'hffff_ffff);
          else begin
            d = exp_q.pop_front();
            chk("data", 32'(out_data), 32'(d));
          end
        end
        prev_rd = (fifo_rd != '0);
      end else begin
        prev_rd = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(idle), 32'd1);
  endtask

  task automatic wait_pop(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (fifo_rd == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(fifo_rd != '0), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state), 32'b00001);
    chk({tag, "_fifo_rd"}, 32'(fifo_rd), 32'd0);
    chk({tag, "_out_wr"}, 32'(out_wr), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_idle_err"}, 32'({idle, error}), 32'd0);
    chk({tag, "_full_thr"}, 32'(full_threshold), 32'd3);
    chk({tag, "_empty_thr"}, 32'(empty_threshold), 32'd1);
  endtask

  initial begin
    int wr_seen;
    reset = 1'b1; init = 1'b0;
    full_threshold_in = '0; empty_threshold_in = '0;
    fifo_error_in = '0; out_almost_full = 1'b0; out_fifo_full = 1'b0; out_error = 1'b0;
    fork monitor(); join_none

    // Reset and threshold configuration
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0; init = 1'b1;
    full_threshold_in = 3'd5; empty_threshold_in = 3'd2;
    @(negedge clk);
    chk("init_state", 32'(state), 32'b00010);
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    chk("idle_state", 32'(state), 32'b00100);
    chk("idle_flag", 32'(idle), 32'd1);
    chk("full_thr_cfg", 32'(full_threshold), 32'd5);
    chk("empty_thr_cfg", 32'(empty_threshold), 32'd2);
    mon_en = 1'b1;

    // FIFOs 0,1,3 hold two words each
    for (int r = 0; r < 2; r++) begin
      push_word(0, r); push_word(1, r); push_word(3, r);
    end
`ifdef STRICT_PRIO_EN
    expect_pop(0, 0); expect_pop(0, 1); expect_pop(1, 0);
    expect_pop(1, 1); expect_pop(3, 0); expect_pop(3, 1);
`else
    for (int r = 0; r < 2; r++) begin
      expect_pop(0, r); expect_pop(1, r); expect_pop(3, r);
    end
`endif
    wait_idle("order_idle", 40);
    chk("order_drained", 32'(exp_q.size() + exp_g_q.size()), 32'd0);

    // Park the pointer on FIFO 1, then FIFO 2 busy with FIFO 0 holding one word
    push_word(1, 5);
    expect_pop(1, 5);
    wait_idle("park_idle", 20);
    for (int s = 0; s < 3; s++) push_word(2, s);
    push_word(0, 9);
`ifdef STRICT_PRIO_EN
    expect_pop(0, 9); expect_pop(2, 0); expect_pop(2, 1); expect_pop(2, 2);
`else
    expect_pop(2, 0); expect_pop(0, 9); expect_pop(2, 1); expect_pop(2, 2);
`endif
    wait_idle("starve_idle", 40);
    chk("starve_drained", 32'(exp_q.size() + exp_g_q.size()), 32'd0);

    // Throttle: almost_full rises in the cycle of a pop
    for (int s = 0; s < 3; s++) begin
      push_word(3, s + 4);
      expect_pop(3, s + 4);
    end
    wait_pop("thr_pop_seen", 20);
    out_almost_full = 1'b1;
    wr_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_wr) wr_seen++;
      chk("thr_no_pop", 32'(fifo_rd), 32'd0);
    end
    chk("thr_one_wr", 32'(wr_seen), 32'd1);
    out_almost_full = 1'b0;
    wait_idle("thr_idle", 40);
    chk("thr_drained", 32'(exp_q.size() + exp_g_q.size()), 32'd0);

    // init while ACTIVE with a word in flight
    for (int s = 0; s < 4; s++) begin
      push_word(0, s + 10);
      expect_pop(0, s + 10);
    end
    wait_pop("init_pop_seen", 20);
    init = 1'b1; full_threshold_in = 3'd6; empty_threshold_in = 3'd3;
    @(negedge clk);
    chk("init_mid_state", 32'(state), 32'b00010);
    chk("init_mid_wr", 32'(out_wr), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("init_mid_no_pop", 32'(fifo_rd), 32'd0);
    end
    chk("init_mid_thr", 32'({full_threshold, empty_threshold}), 32'({3'd6, 3'd3}));
    init = 1'b0;
    wait_idle("init_mid_idle", 40);
    chk("init_mid_drained", 32'(exp_q.size() + exp_g_q.size()), 32'd0);

    // Input FIFO error during ACTIVE, sticky until reset
    mon_en = 1'b0;
    for (int s = 0; s < 4; s++) push_word(1, s);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (state != 5'b01000 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("err_active_seen", 32'(state), 32'b01000);
    end
    fifo_error_in = 4'b0010;
    @(negedge clk);
    chk("err_state", 32'(state), 32'b10000);
    chk("err_flag", 32'(error), 32'd1);
    fifo_error_in = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("err_no_pop", 32'(fifo_rd), 32'd0);
      chk("err_sticky", 32'(state), 32'b10000);
    end
    reset = 1'b1;
    for (int i = 0; i < N; i++) wr_cnt[i] = rd_cnt[i];
    @(negedge clk);
    check_reset_values("rst2");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_idle", 32'(state), 32'b00100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
Controller that drains N_FIFOS input FIFOs into one shared output FIFO, one word per cycle, with round-robin arbitration. It configures the almost_full/almost_empty thresholds of every FIFO, throttles on output almost_full, and sequences operation through a RESET/INIT/IDLE/ACTIVE/ERROR state machine. It sits between the per-channel FIFOs and the downstream output FIFO.

Parameters:
N_FIFOS, 4, number of input FIFOs (requesters)
WORD_SIZE, 6, data word width in bits
PTR_L, 3, threshold and pointer width
FULL_DEF, 3, full-threshold value loaded on reset
EMPTY_DEF, 1, empty-threshold value loaded on reset

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high reset
init  in  1  requests (re)configuration of thresholds
full_threshold_in  in  PTR_L  full threshold captured in INIT
empty_threshold_in  in  PTR_L  empty threshold captured in INIT
fifo_empty_in  in  N_FIFOS  empty flag of each input FIFO
fifo_error_in  in  N_FIFOS  error flag of each input FIFO
fifo_data_in  in  N_FIFOS*WORD_SIZE  read data of each input FIFO; slice i = bits [i*WORD_SIZE +: WORD_SIZE]
out_almost_full  in  1  almost_full of the output FIFO
out_fifo_full  in  1  full of the output FIFO
out_error  in  1  error of the output FIFO
fifo_rd  out  N_FIFOS  one-hot pop strobe to the input FIFOs
out_wr  out  1  push strobe to the output FIFO
out_data  out  WORD_SIZE  word pushed to the output FIFO
full_threshold  out  PTR_L  threshold broadcast to all FIFOs
empty_threshold  out  PTR_L  threshold broadcast to all FIFOs
state  out  5  one-hot state: [0]RESET [1]INIT [2]IDLE [3]ACTIVE [4]ERROR
idle  out  1  high while in IDLE
error  out  1  high while in ERROR

Behaviour:
- Reset (reset=1 at a posedge): state=RESET (5'b00001); fifo_rd=0, out_wr=0, out_data=0, idle=0, error=0; full_threshold=FULL_DEF, empty_threshold=EMPTY_DEF; rr pointer=N_FIFOS-1, so input 0 is first; in-flight flag cleared. Reset mid-operation drops any in-flight word.
- Transitions evaluated each posedge. Priority: reset > error > init > others.
- RESET -> INIT unconditionally on the next posedge.
- INIT: while init=1, thresholds are registered from *_threshold_in every cycle. init=0 -> IDLE. No pops.
- IDLE: idle=1. init=1 -> INIT. Any input non-empty -> ACTIVE.
- ACTIVE: init=1 -> INIT. All inputs empty and no in-flight word -> IDLE.
- Any state except RESET: any fifo_error_in bit, out_error, or out_wr with out_fifo_full -> ERROR. ERROR is sticky until reset. error=1 one cycle after detection.
- Arbitration, in ACTIVE only, when out_almost_full=0: grant the first index with fifo_empty_in=0, searching cyclically from rr_pointer+1. fifo_rd[grant]=1 is registered and lasts one cycle. rr_pointer<=grant. At most one pop per cycle; back-to-back pops to the same FIFO are allowed if it is still non-empty.
- Latency: the pop strobe is high in cycle t; the FIFO presents data in cycle t+1; in cycle t+1, out_wr=1 and out_data = slice[grant registered at t]. out_data holds its value when out_wr=0. Throughput is 1 word/cycle.
- Throttle: out_almost_full=1 blocks new pops. The single in-flight word still writes. The output FIFO threshold must leave at least 1 free entry.
- Leaving ACTIVE (to INIT/ERROR): no new pops are issued; an in-flight word completes its out_wr in the following cycle.
- The grant index uses a $clog2(N_FIFOS)-bit register; the pointer wraps N_FIFOS-1 -> 0.

Optional Feature:
STRICT_PRIO_EN: when defined, arbitration is fixed priority (lowest non-empty index wins), and rr_pointer is neither used nor updated. When undefined, round-robin as above. All other behaviour is identical.

Test Plan:
- Reset then init=1 with thresholds 5/2 for 2 cycles, then init=0 -> state 00001 -> 00010 -> 00100; full_threshold=5, empty_threshold=2.
- FIFOs 0,1,3 each holding 2 words, none full, out not almost_full -> pop order 0,1,3,0,1,3; out_wr one cycle after each fifo_rd with matching data; then return to IDLE (idle=1).
- FIFO 2 continuously non-empty, FIFO 0 gets 1 word -> grants alternate 2,0,2; no starvation (with STRICT_PRIO_EN: 0 first, then 2).
- out_almost_full rises the same cycle as a pop -> exactly one out_wr follows, no further fifo_rd until almost_full=0.
- fifo_error_in[1]=1 during ACTIVE -> state=10000 next cycle, error=1; fifo_rd stays 0 until reset=1.
- init=1 while ACTIVE with a word in flight -> out_wr still occurs once; state=INIT; no further pops.
